commit_queue_ctrl: RTL and testbench



---
 rtl/commit_queue_ctrl_pkg.sv | 21 ++
 rtl/commit_queue_ctrl_if.sv | 27 ++
 rtl/cmt_retire_sel.sv | 39 +++
 rtl/commit_queue_ctrl.sv | 105 ++++++++++
 tb/tb_commit_queue_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/commit_queue_ctrl_pkg.sv
// Shared commit-path types: register/result widths, the commit request record and queue depth.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package commit_queue_ctrl_pkg;

    localparam int REG_ADDR  = 5;
    localparam int REG_WIDTH = 32;
    localparam int CMT_QUEUE_DEPTH = 8;

    typedef logic bool;

    typedef struct packed {
        bool                  write_reg_need;
        logic [REG_ADDR-1:0]  write_reg_addr;
        logic [REG_WIDTH-1:0] result;
    } CMT_REQUIRE;

    // Idle value driven on an unused commit slot.
    localparam CMT_REQUIRE CMT_ZERO = '0;

endpackage

// File: rtl/commit_queue_ctrl_if.sv
// Execute-lane enqueue and commit-stage presentation signals of the commit queue.
// Latency: none (wiring only).
// Backpressure: enq_ready from the queue; cmt_stall from the commit stage.
interface commit_queue_ctrl_if;
    import commit_queue_ctrl_pkg::*;

    logic [1:0]       enq_valid;
    CMT_REQUIRE [1:0] enq_req;
    logic             enq_ready;
    logic             cmt_stall;
    logic             flush;
    CMT_REQUIRE [1:0] cmt_require;
    logic [1:0]       retire_cnt;
    logic             empty;

    // Producer / commit-stage side.
    modport master (
        output enq_valid, enq_req, cmt_stall, flush,
        input  enq_ready, cmt_require, retire_cnt, empty
    );

    // Queue side.
    modport slave (
        input  enq_valid, enq_req, cmt_stall, flush,
        output enq_ready, cmt_require, retire_cnt, empty
    );
endinterface

// File: rtl/cmt_retire_sel.sv
// Picks which of the two oldest entries go to the commit stage; splits same-address pairs.
// Latency: purely combinational.
// Backpressure: hold (stall or flush) forces retire_cnt to 0 while still presenting slots.
module cmt_retire_sel
    import commit_queue_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  CMT_REQUIRE       head0,
    input  CMT_REQUIRE       head1,
    input  logic [CNT_W-1:0] count,
    input  logic             hold,
    output CMT_REQUIRE [1:0] slot,
    output logic [1:0]       retire_cnt
);

    logic have1;
    logic have2;
    logic split;

    // Slot selection and retire count; slot1 only ever accompanies slot0.
    always_comb begin
        slot       = {CMT_ZERO, CMT_ZERO};
        retire_cnt = 2'd0;
        have1      = (count != '0);
        have2      = (count >= CNT_W'(2));
        split      = have2 && (head0.write_reg_addr == head1.write_reg_addr);
        if (have1) begin
            slot[0] = head0;
        end
        if (have2 && !split) begin
            slot[1] = head1;
        end
        if (have1 && !hold) begin
            retire_cnt = (have2 && !split) ? 2'd2 : 2'd1;
        end
    end

endmodule

// File: rtl/commit_queue_ctrl.sv
// In-order commit queue: buffers two-lane completions, presents up to two head entries (CMT_QUEUE_STAT_EN adds counters).
// Latency: entry enqueued at edge N is presented in cycle N+1 and may retire at edge N+1.
// Backpressure: enq_ready low when fewer than 2 entries free (inputs ignored); cmt_stall holds retirement.
module commit_queue_ctrl
    import commit_queue_ctrl_pkg::*;
#(
    parameter int DEPTH = CMT_QUEUE_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                resetn,
    commit_queue_ctrl_if.slave  cq
`ifdef CMT_QUEUE_STAT_EN
    ,
    output logic [31:0]         stat_retired,
    output logic [31:0]         stat_split
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    CMT_REQUIRE       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_nx1;
    logic [PTR_W-1:0] tail_nx1;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [1:0]       enq_n;
    logic [1:0]       retire_cnt;
    CMT_REQUIRE [1:0] slot;

    assign head_nx1     = head + PTR_W'(1);
    assign tail_nx1     = tail + PTR_W'(1);
    assign cq.enq_ready = ((CNT_W'(DEPTH) - count) >= CNT_W'(2));
    assign cq.empty     = (count == '0);
    assign cq.cmt_require = slot;
    assign cq.retire_cnt  = retire_cnt;
    assign count_next   = count + CNT_W'(enq_n) - CNT_W'(retire_cnt);

    // Number of lanes accepted this cycle; the illegal {1,0} pattern enqueues nothing.
    always_comb begin
        enq_n = 2'd0;
        if (cq.enq_ready) begin
            case (cq.enq_valid)
                2'b01:   enq_n = 2'd1;
                2'b11:   enq_n = 2'd2;
                default: enq_n = 2'd0;
            endcase
        end
    end

    cmt_retire_sel #(
        .CNT_W (CNT_W)
    ) u_retire_sel (
        .head0      (mem[head]),
        .head1      (mem[head_nx1]),
        .count      (count),
        .hold       (cq.cmt_stall | cq.flush),
        .slot       (slot),
        .retire_cnt (retire_cnt)
    );

    // Pointer and occupancy update; flush discards same-cycle enqueue and retire.
    always_ff @(posedge clk) begin
        if (!resetn || cq.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(retire_cnt);
            tail  <= tail + PTR_W'(enq_n);
            count <= count_next;
        end
    end

    // Entry storage; contents are only read once written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (resetn && !cq.flush) begin
            if (enq_n != 2'd0) begin
                mem[tail] <= cq.enq_req[0];
            end
            if (enq_n == 2'd2) begin
                mem[tail_nx1] <= cq.enq_req[1];
            end
        end
    end

`ifdef CMT_QUEUE_STAT_EN
    // Retirement statistics; survive flush. One retired entry with two or more
    // buffered means the pair was split on a shared destination.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_retired <= '0;
            stat_split   <= '0;
        end else begin
            stat_retired <= stat_retired + 32'(retire_cnt);
            if (retire_cnt == 2'd1 && count >= CNT_W'(2)) begin
                stat_split <= stat_split + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_commit_queue_ctrl.sv
// Directed vector bench for commit_queue_ctrl at DEPTH=8.
// Latency: inputs driven at negedge, outputs sampled 2 time units later, state moves at posedge.
// Backpressure: exercised through cmt_stall fill and enq_ready drop.
module tb_commit_queue_ctrl;
    import commit_queue_ctrl_pkg::*;

    typedef struct {
        logic       rn;
        logic [1:0] v;
        CMT_REQUIRE q0;
        CMT_REQUIRE q1;
        logic       st;
        logic       fl;
        logic       erdy;
        logic       eemp;
        logic [1:0] erc;
        CMT_REQUIRE s0;
        CMT_REQUIRE s1;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    commit_queue_ctrl_if cq();

`ifdef CMT_QUEUE_STAT_EN
    logic [31:0] stat_retired;
    logic [31:0] stat_split;
    logic [31:0] exp_ret;
    logic [31:0] exp_split;
`endif

    commit_queue_ctrl #(
        .DEPTH (8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .cq     (cq)
`ifdef CMT_QUEUE_STAT_EN
        ,
        .stat_retired (stat_retired),
        .stat_split   (stat_split)
`endif
    );

    function automatic CMT_REQUIRE ent(input logic [4:0] a, input logic [31:0] r);
        CMT_REQUIRE e;
        e.write_reg_need = 1'b1;
        e.write_reg_addr = a;
        e.result         = r;
        return e;
    endfunction

    function automatic vec_t mv(input logic rn, input logic [1:0] v, input CMT_REQUIRE q0, input CMT_REQUIRE q1,
                                input logic st, input logic fl, input logic erdy, input logic eemp,
                                input logic [1:0] erc, input CMT_REQUIRE s0, input CMT_REQUIRE s1);
        vec_t x;
        x.rn = rn; x.v = v; x.q0 = q0; x.q1 = q1; x.st = st; x.fl = fl;
        x.erdy = erdy; x.eemp = eemp; x.erc = erc; x.s0 = s0; x.s1 = s1;
        return x;
    endfunction

    task automatic drive(input logic rn, input logic [1:0] v, input CMT_REQUIRE q0, input CMT_REQUIRE q1,
                         input logic st, input logic fl);
        resetn       = rn;
        cq.enq_valid = v;
        cq.enq_req   = {q1, q0};
        cq.cmt_stall = st;
        cq.flush     = fl;
    endtask

    task automatic check(input string tag, input logic erdy, input logic eemp, input logic [1:0] erc,
                         input CMT_REQUIRE s0, input CMT_REQUIRE s1);
        n_cmp++;
        if (cq.enq_ready !== erdy) begin
            n_bad++;
            $display("FAIL %s enq_ready got %b want %b", tag, cq.enq_ready, erdy);
        end
        n_cmp++;
        if (cq.empty !== eemp) begin
            n_bad++;
            $display("FAIL %s empty got %b want %b", tag, cq.empty, eemp);
        end
        n_cmp++;
        if (cq.retire_cnt !== erc) begin
            n_bad++;
            $display("FAIL %s retire_cnt got %0d want %0d", tag, cq.retire_cnt, erc);
        end
        n_cmp++;
        if (cq.cmt_require[0] !== s0) begin
            n_bad++;
            $display("FAIL %s slot0 got %h want %h", tag, cq.cmt_require[0], s0);
        end
        n_cmp++;
        if (cq.cmt_require[1] !== s1) begin
            n_bad++;
            $display("FAIL %s slot1 got %h want %h", tag, cq.cmt_require[1], s1);
        end
    endtask

    initial begin
        CMT_REQUIRE z;
        z = CMT_ZERO;

        // Basic pair, split pair
        tbl.push_back(mv(1, 2'b11, ent(3, 'hA), ent(4, 'hB), 0, 0, 1, 1, 0, z, z));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 0, 2, ent(3, 'hA), ent(4, 'hB)));
        tbl.push_back(mv(1, 2'b11, ent(5, 'h51), ent(5, 'h52), 0, 0, 1, 1, 0, z, z));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 0, 1, ent(5, 'h51), z));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 0, 1, ent(5, 'h52), z));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 1, 0, z, z));
        // Fill under stall, ignored enqueues, drain in order
        tbl.push_back(mv(1, 2'b11, ent(1, 'h11), ent(2, 'h12), 1, 0, 1, 1, 0, z, z));
        tbl.push_back(mv(1, 2'b11, ent(3, 'h13), ent(4, 'h14), 1, 0, 1, 0, 0, ent(1, 'h11), ent(2, 'h12)));
        tbl.push_back(mv(1, 2'b11, ent(5, 'h15), ent(6, 'h16), 1, 0, 1, 0, 0, ent(1, 'h11), ent(2, 'h12)));
        tbl.push_back(mv(1, 2'b11, ent(7, 'h17), ent(8, 'h18), 1, 0, 1, 0, 0, ent(1, 'h11), ent(2, 'h12)));
        tbl.push_back(mv(1, 2'b11, ent(9, 'h99), ent(10, 'h9A), 1, 0, 0, 0, 0, ent(1, 'h11), ent(2, 'h12)));
        tbl.push_back(mv(1, 2'b01, ent(9, 'h99), z, 1, 0, 0, 0, 0, ent(1, 'h11), ent(2, 'h12)));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 0, 0, 2, ent(1, 'h11), ent(2, 'h12)));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 0, 2, ent(3, 'h13), ent(4, 'h14)));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 0, 2, ent(5, 'h15), ent(6, 'h16)));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 0, 2, ent(7, 'h17), ent(8, 'h18)));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 1, 0, z, z));
        // Singles overlapping enqueue and retire, then a pair straddling index 7 -> 0
        tbl.push_back(mv(1, 2'b01, ent(11, 'h21), z, 0, 0, 1, 1, 0, z, z));
        tbl.push_back(mv(1, 2'b01, ent(12, 'h22), z, 0, 0, 1, 0, 1, ent(11, 'h21), z));
        tbl.push_back(mv(1, 2'b01, ent(13, 'h23), z, 0, 0, 1, 0, 1, ent(12, 'h22), z));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 0, 1, ent(13, 'h23), z));
        tbl.push_back(mv(1, 2'b11, ent(14, 'h24), ent(15, 'h25), 0, 0, 1, 1, 0, z, z));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 0, 2, ent(14, 'h24), ent(15, 'h25)));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 1, 0, z, z));
        // Flush at count=5 with a same-cycle pair enqueue
        tbl.push_back(mv(1, 2'b11, ent(16, 'h31), ent(17, 'h32), 1, 0, 1, 1, 0, z, z));
        tbl.push_back(mv(1, 2'b11, ent(18, 'h33), ent(19, 'h34), 1, 0, 1, 0, 0, ent(16, 'h31), ent(17, 'h32)));
        tbl.push_back(mv(1, 2'b01, ent(20, 'h35), z, 1, 0, 1, 0, 0, ent(16, 'h31), ent(17, 'h32)));
        tbl.push_back(mv(1, 2'b11, ent(21, 'h41), ent(22, 'h42), 0, 1, 1, 0, 0, ent(16, 'h31), ent(17, 'h32)));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 1, 0, z, z));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 1, 0, z, z));
        // Mid-stream reset at count=3
        tbl.push_back(mv(1, 2'b11, ent(1, 'h51), ent(2, 'h52), 1, 0, 1, 1, 0, z, z));
        tbl.push_back(mv(1, 2'b01, ent(3, 'h53), z, 1, 0, 1, 0, 0, ent(1, 'h51), ent(2, 'h52)));
        tbl.push_back(mv(0, 2'b11, ent(4, 'h54), ent(5, 'h55), 1, 0, 1, 0, 0, ent(1, 'h51), ent(2, 'h52)));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 1, 0, z, z));
        tbl.push_back(mv(1, 2'b01, ent(6, 'h61), z, 0, 0, 1, 1, 0, z, z));
        tbl.push_back(mv(1, 2'b00, z, z, 0, 0, 1, 0, 1, ent(6, 'h61), z));

        drive(0, 2'b00, z, z, 0, 0);
        repeat (2) @(posedge clk);
`ifdef CMT_QUEUE_STAT_EN
        exp_ret   = '0;
        exp_split = '0;
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rn, tbl[i].v, tbl[i].q0, tbl[i].q1, tbl[i].st, tbl[i].fl);
            #2;
            check($sformatf("vec%0d", i), tbl[i].erdy, tbl[i].eemp, tbl[i].erc, tbl[i].s0, tbl[i].s1);
`ifdef CMT_QUEUE_STAT_EN
            n_cmp++;
            if (stat_retired !== exp_ret) begin
                n_bad++;
                $display("FAIL vec%0d stat_retired got %0d want %0d", i, stat_retired, exp_ret);
            end
            n_cmp++;
            if (stat_split !== exp_split) begin
                n_bad++;
                $display("FAIL vec%0d stat_split got %0d want %0d", i, stat_split, exp_split);
            end
            if (!tbl[i].rn) begin
                exp_ret   = '0;
                exp_split = '0;
            end else begin
                exp_ret = exp_ret + 32'(tbl[i].erc);
                if (i == 3) exp_split = exp_split + 32'd1;
            end
`endif
        end

        // From reset: 7 singles walk the pointers to index 7, then a pair lands at 7 and 0.
        @(negedge clk);
        drive(0, 2'b00, z, z, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            drive(1, 2'b01, ent(5'(i + 1), 32'('h70 + i)), z, 0, 0);
            #2;
            if (i == 0) check("wrap_single0", 1, 1, 0, z, z);
            else        check($sformatf("wrap_single%0d", i), 1, 0, 1, ent(5'(i), 32'('h70 + i - 1)), z);
            @(negedge clk);
        end
        drive(1, 2'b11, ent(20, 'h80), ent(21, 'h81), 0, 0);
        #2;
        check("wrap_pair_enq", 1, 0, 1, ent(7, 'h76), z);
        @(negedge clk);
        drive(1, 2'b00, z, z, 0, 0);
        #2;
        check("wrap_pair", 1, 0, 2, ent(20, 'h80), ent(21, 'h81));
        @(negedge clk);
        #2;
        check("wrap_empty", 1, 1, 0, z, z);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
